// File: rtl/ann_mac_pkg.sv
// ann_mac_pkg: shared definitions for the single-neuron MAC slave.
// Contents: register word addresses, CTRL/STATUS bit positions, the
// sequencer state enum and the int32 saturation helper.
package ann_mac_pkg;

    // Word addresses on the Avalon-MM slave
    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_LEN    = 3'd1;
    localparam logic [2:0] ADDR_XDATA  = 3'd2;
    localparam logic [2:0] ADDR_WDATA  = 3'd3;
    localparam logic [2:0] ADDR_RESULT = 3'd4;
    localparam logic [2:0] ADDR_STATUS = 3'd5;

    // CTRL bit positions
    localparam int CTRL_START   = 0;
    localparam int CTRL_CLR_PTR = 1;
    localparam int CTRL_RELU_EN = 2;
    localparam int CTRL_IRQ_EN  = 3;

    // STATUS bit positions
    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;
    localparam int STAT_OVF  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } mac_state_e;

    typedef struct packed {
        logic [31:0] value;
        logic        ovf;
    } sat_t;

    // Clamp a wide signed value into int32. The value fits when every bit
    // from 63 down to 31 equals the int32 sign bit.
    function automatic sat_t sat32(input logic signed [63:0] v);
        sat_t r;
        if (v[63:31] == {33{v[31]}}) begin
            r.value = v[31:0];
            r.ovf   = 1'b0;
        end else begin
            r.value = v[63] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            r.ovf   = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ann_mac_slave_if.sv
// ann_mac_slave_if: Avalon-MM bus between the HPS lightweight bridge
// (master) and the MAC slave.
// Signals: avs_address (word), avs_write/avs_writedata, avs_read,
// avs_readdata, avs_waitrequest.
// Handshake: a transfer happens on every clock edge where avs_write or
// avs_read is high; avs_waitrequest is held low so no transfer ever
// stalls, and avs_readdata is valid on the cycle after the avs_read cycle
// (fixed read latency 1).
interface ann_mac_slave_if;
    logic [2:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;

    modport master (
        output avs_address, avs_write, avs_writedata, avs_read,
        input  avs_readdata, avs_waitrequest
    );

    modport slave (
        input  avs_address, avs_write, avs_writedata, avs_read,
        output avs_readdata, avs_waitrequest
    );
endinterface

// File: rtl/ann_mac_unit.sv
// ann_mac_unit: product register followed by accumulator.
// Ports: clk, rst (sync, active-high), clear (zeroes product stage and
// accumulator), valid (x/w pair is live this cycle), x, w (signed
// operands), acc (signed running sum, sign-extended products).
module ann_mac_unit #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     valid,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] w,
    output logic signed [ACC_W-1:0]  acc
);
    logic signed [2*DATA_W-1:0] prod;
    logic                       prod_valid;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            prod       <= '0;
            prod_valid <= 1'b0;
            acc        <= '0;
        end else begin
            prod       <= x * w;
            prod_valid <= valid;
            if (prod_valid)
                acc <= acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
        end
    end
endmodule

// File: rtl/ann_mac_slave.sv
// ann_mac_slave: one-neuron dot-product engine behind the HPS lightweight
// bridge. Software loads X and W vectors, writes START, and reads RESULT
// (optionally ReLU'd, saturated to int32).
// Ports: clk_clk, reset_reset (sync, active-high), avs (Avalon-MM slave
// modport), irq (done & IRQ_EN), status_leds {done,busy,err,ovf,4'b0},
// dbg_state (current sequencer state).
module ann_mac_slave
    import ann_mac_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 64,
    parameter int ACC_W  = 40
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset,
    ann_mac_slave_if.slave       avs,
    output logic                 irq,
    output logic [7:0]           status_leds,
    output mac_state_e           dbg_state
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LEN_W = PTR_W + 1;

    mac_state_e        state;
    logic [LEN_W-1:0]  len;
    logic [PTR_W-1:0]  xptr, wptr, idx;
    logic              drain_cnt;
    logic              relu_en, irq_en;
    logic              busy, done, err, ovf;
    logic [31:0]       result;
    logic [31:0]       rdata_q;
    logic              rd_valid;

    logic signed [DATA_W-1:0] x_mem [DEPTH];
    logic signed [DATA_W-1:0] w_mem [DEPTH];
    logic signed [DATA_W-1:0] x_rd, w_rd;
    logic signed [ACC_W-1:0]  acc;

    // Write decode
    logic [31:0] wd;
    logic wr_ctrl, wr_len, wr_xdata, wr_wdata, wr_status;
    logic start_bit, clr_bit, start_go;

    assign wd        = avs.avs_writedata;
    assign wr_ctrl   = avs.avs_write && (avs.avs_address == ADDR_CTRL);
    assign wr_len    = avs.avs_write && (avs.avs_address == ADDR_LEN);
    assign wr_xdata  = avs.avs_write && (avs.avs_address == ADDR_XDATA);
    assign wr_wdata  = avs.avs_write && (avs.avs_address == ADDR_WDATA);
    assign wr_status = avs.avs_write && (avs.avs_address == ADDR_STATUS);
    assign start_bit = wr_ctrl && wd[CTRL_START];
    assign clr_bit   = wr_ctrl && wd[CTRL_CLR_PTR];
    // CLR_PTR takes priority over START when both are written together.
    assign start_go  = start_bit && !clr_bit && !busy;

    // LEN is clamped into 1..DEPTH on the way in.
    logic [LEN_W-1:0] len_in;
    always_comb begin
        len_in = wd[LEN_W-1:0];
        if (wd == 32'd0)
            len_in = LEN_W'(1);
        else if (wd > 32'(DEPTH))
            len_in = LEN_W'(DEPTH);
    end

    // Vector RAMs: no reset so they map onto block RAM.
    always_ff @(posedge clk_clk) begin
        if (wr_xdata && !busy) x_mem[xptr] <= wd[DATA_W-1:0];
        if (wr_wdata && !busy) w_mem[wptr] <= wd[DATA_W-1:0];
        x_rd <= x_mem[idx];
        w_rd <= w_mem[idx];
    end

    ann_mac_unit #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_unit (
        .clk   (clk_clk),
        .rst   (reset_reset),
        .clear (start_go),
        .valid (rd_valid),
        .x     (x_rd),
        .w     (w_rd),
        .acc   (acc)
    );

    // Result stage: ReLU short-circuits negatives, otherwise clamp to int32.
    logic signed [63:0] acc_ext;
    sat_t               sat_r;
    logic [31:0]        res_val;
    logic               res_ovf;
    assign acc_ext = {{(64-ACC_W){acc[ACC_W-1]}}, acc};
    assign sat_r   = sat32(acc_ext);
    always_comb begin
        res_val = sat_r.value;
        res_ovf = sat_r.ovf;
        if (relu_en && acc[ACC_W-1]) begin
            res_val = 32'd0;
            res_ovf = 1'b0;
        end
    end

    // Read mux, sampled before this cycle's write takes effect.
    logic [31:0] rd_mux;
    always_comb begin
        rd_mux = 32'd0;
        case (avs.avs_address)
            ADDR_CTRL:   rd_mux = {28'd0, irq_en, relu_en, 2'b00};
            ADDR_LEN:    rd_mux = 32'(len);
            ADDR_RESULT: rd_mux = result;
            ADDR_STATUS: rd_mux = {8'd0, 8'(wptr), 8'(xptr), 4'd0, ovf, err, done, busy};
            default:     rd_mux = 32'd0;
        endcase
    end

    // CSR + sequencer. Later assignments in this block deliberately
    // override earlier ones (e.g. the DONE state's done<=1 beats a clear).
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state     <= ST_IDLE;
            len       <= LEN_W'(1);
            xptr      <= '0;
            wptr      <= '0;
            idx       <= '0;
            drain_cnt <= 1'b0;
            relu_en   <= 1'b0;
            irq_en    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            ovf       <= 1'b0;
            result    <= '0;
            rdata_q   <= '0;
            rd_valid  <= 1'b0;
        end else begin
            if (avs.avs_read)
                rdata_q <= rd_mux;

            rd_valid <= (state == ST_RUN);

            if (wr_ctrl) begin
                relu_en <= wd[CTRL_RELU_EN];
                irq_en  <= wd[CTRL_IRQ_EN];
            end

            if (wr_status) begin
                if (wd[STAT_ERR]) err <= 1'b0;
                if (wd[STAT_OVF]) ovf <= 1'b0;
                if (wd[STAT_DONE] && !busy) done <= 1'b0;
            end

            if (busy) begin
                if (wr_len || wr_xdata || wr_wdata || start_bit)
                    err <= 1'b1;
            end else begin
                if (wr_len) len <= len_in;
                if (clr_bit) begin
                    xptr <= '0;
                    wptr <= '0;
                end
                if (wr_xdata) xptr <= xptr + PTR_W'(1);
                if (wr_wdata) wptr <= wptr + PTR_W'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (start_go) begin
                        state <= ST_RUN;
                        idx   <= '0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    idx <= idx + PTR_W'(1);
                    if ({1'b0, idx} == len - LEN_W'(1)) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    // Two cycles: RAM read and product stage empty out.
                    drain_cnt <= 1'b1;
                    if (drain_cnt)
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    result <= res_val;
                    if (res_ovf) ovf <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign avs.avs_readdata    = rdata_q;
    assign avs.avs_waitrequest = 1'b0;
    assign irq                 = done && irq_en;
    assign status_leds         = {done, busy, err, ovf, 4'b0000};
    assign dbg_state           = state;
endmodule

// File: tb/tb_ann_mac_slave.sv
module tb_ann_mac_slave;
    import ann_mac_pkg::*;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       irq;
    logic [7:0] leds;
    mac_state_e dbg_state;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ann_mac_slave_if bus ();

    ann_mac_slave #(.DATA_W(16), .DEPTH(64), .ACC_W(40)) dut (
        .clk_clk     (clk),
        .reset_reset (rst),
        .avs         (bus),
        .irq         (irq),
        .status_leds (leds),
        .dbg_state   (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.avs_address   = a;
        bus.avs_writedata = d;
        bus.avs_write     = 1'b1;
        @(posedge clk);
        #1;
        bus.avs_write     = 1'b0;
    endtask

    task automatic rd_chk(input logic [2:0] a, input logic [31:0] exp, input string name);
        logic [31:0] e;
        exp_q.push_back(exp);
        @(negedge clk);
        bus.avs_address = a;
        bus.avs_read    = 1'b1;
        @(posedge clk);
        #1;
        bus.avs_read    = 1'b0;
        e = exp_q.pop_front();
        chk(name, bus.avs_readdata, e);
    endtask

    task automatic start_run(input logic [31:0] ctrl, output int t0);
        wr(ADDR_CTRL, ctrl);
        t0 = cyc;
    endtask

    // Bounded wait for busy to fall; checks cycles since the START edge.
    task automatic wait_done(input int t0, input int exp_cycles, input string name);
        int n;
        n = 0;
        while (leds[6] && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (leds[6]) begin
            checks++;
            errors++;
            $display("FAIL %s: busy still high after %0d cycles", name, n);
        end else begin
            chk(name, 32'(cyc - t0), 32'(exp_cycles));
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int               len;
        logic [3:0][15:0] x;     // element 0 rightmost
        logic [3:0][15:0] w;
        logic             relu;
        logic [31:0]      exp_res;
    } vec_t;

    vec_t vecs[5];

    task automatic load_vec(input vec_t v);
        wr(ADDR_CTRL, 32'h2);
        wr(ADDR_LEN, 32'(v.len));
        for (int i = 0; i < v.len; i++) wr(ADDR_XDATA, {16'd0, v.x[i]});
        for (int i = 0; i < v.len; i++) wr(ADDR_WDATA, {16'd0, v.w[i]});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t0;
        logic [31:0] st;

        bus.avs_address   = 3'd0;
        bus.avs_write     = 1'b0;
        bus.avs_writedata = 32'd0;
        bus.avs_read      = 1'b0;

        vecs[0] = '{4, {16'd4, 16'd3, 16'd2, 16'd1}, {16'd8, 16'd7, 16'd6, 16'd5}, 1'b0, 32'd70};
        vecs[1] = '{2, {16'd0, 16'd0, 16'd2, -16'sd3}, {16'd0, 16'd0, 16'd1, 16'd4}, 1'b0, 32'hFFFF_FFF6};
        vecs[2] = '{2, {16'd0, 16'd0, 16'd2, -16'sd3}, {16'd0, 16'd0, 16'd1, 16'd4}, 1'b1, 32'd0};
        vecs[3] = '{3, {16'd0, 16'd100, 16'h8000, 16'h8000}, {16'd0, -16'sd1, 16'd1, 16'h8000}, 1'b0, 32'h3FFF_7F9C};
        vecs[4] = '{4, {16'd0, -16'sd5, 16'd20, 16'd10}, {16'd9, 16'd3, 16'd3, 16'd3}, 1'b1, 32'd75};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_leds", 32'(leds), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_readdata", bus.avs_readdata, 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rd_chk(ADDR_CTRL, 32'd0, "rst_ctrl");
        rd_chk(ADDR_LEN, 32'd1, "rst_len");
        rd_chk(ADDR_RESULT, 32'd0, "rst_result");
        rd_chk(ADDR_STATUS, 32'd0, "rst_status");

        // Table-driven dot products
        for (int i = 0; i < 5; i++) begin
            load_vec(vecs[i]);
            start_run(32'h1 | (32'(vecs[i].relu) << 2), t0);
            wait_done(t0, vecs[i].len + 3, $sformatf("vec%0d_latency", i));
            chk($sformatf("vec%0d_irq", i), 32'(irq), 32'd0);
            rd_chk(ADDR_RESULT, vecs[i].exp_res, $sformatf("vec%0d_result", i));
            st = 32'h2 | (32'(vecs[i].len) << 8) | (32'(vecs[i].len) << 16);
            rd_chk(ADDR_STATUS, st, $sformatf("vec%0d_status", i));
            wr(ADDR_STATUS, 32'h2);
        end

        // Positive saturation, then ovf clear
        wr(ADDR_CTRL, 32'h2);
        wr(ADDR_LEN, 32'd64);
        for (int i = 0; i < 64; i++) wr(ADDR_XDATA, 32'h7FFF);
        for (int i = 0; i < 64; i++) wr(ADDR_WDATA, 32'h7FFF);
        start_run(32'h1, t0);
        wait_done(t0, 67, "satp_latency");
        rd_chk(ADDR_RESULT, 32'h7FFF_FFFF, "satp_result");
        rd_chk(ADDR_STATUS, 32'h0000_000A, "satp_status");
        wr(ADDR_STATUS, 32'h8);
        rd_chk(ADDR_STATUS, 32'h0000_0002, "satp_ovf_clr");
        wr(ADDR_STATUS, 32'h2);

        // Negative saturation
        wr(ADDR_CTRL, 32'h2);
        for (int i = 0; i < 64; i++) wr(ADDR_XDATA, 32'h8000);
        for (int i = 0; i < 64; i++) wr(ADDR_WDATA, 32'h7FFF);
        start_run(32'h1, t0);
        wait_done(t0, 67, "satn_latency");
        rd_chk(ADDR_RESULT, 32'h8000_0000, "satn_result");
        rd_chk(ADDR_STATUS, 32'h0000_000A, "satn_status");
        wr(ADDR_STATUS, 32'hA);
        rd_chk(ADDR_STATUS, 32'h0000_0000, "satn_clr");

        // Busy protection: XDATA write and second START during RUN
        load_vec(vecs[0]);
        start_run(32'h1, t0);
        wr(ADDR_XDATA, 32'd9);
        wr(ADDR_CTRL, 32'h1);
        wait_done(t0, 7, "busy_latency");
        rd_chk(ADDR_RESULT, 32'd70, "busy_result");
        rd_chk(ADDR_STATUS, 32'h0004_0406, "busy_status");
        wr(ADDR_STATUS, 32'h6);
        rd_chk(ADDR_STATUS, 32'h0004_0400, "busy_clr");

        // Interrupt, pointer wrap, CLR_PTR
        wr(ADDR_CTRL, 32'h2);
        wr(ADDR_LEN, 32'd1);
        wr(ADDR_XDATA, 32'd3);
        wr(ADDR_WDATA, 32'hFFFE);
        start_run(32'h9, t0);
        wait_done(t0, 4, "irq_latency");
        chk("irq_high", 32'(irq), 32'd1);
        rd_chk(ADDR_RESULT, 32'hFFFF_FFFA, "irq_result");
        wr(ADDR_STATUS, 32'h2);
        chk("irq_cleared", 32'(irq), 32'd0);
        wr(ADDR_CTRL, 32'h2);
        for (int i = 0; i < 65; i++) wr(ADDR_XDATA, 32'(i));
        rd_chk(ADDR_STATUS, 32'h0000_0100, "ptr_wrap");
        wr(ADDR_CTRL, 32'h2);
        rd_chk(ADDR_STATUS, 32'h0000_0000, "ptr_clr");
        wr(ADDR_XDATA, 32'd1);
        wr(ADDR_CTRL, 32'h3);
        chk("clr_start_busy", 32'(leds[6]), 32'd0);
        rd_chk(ADDR_STATUS, 32'h0000_0000, "clr_start_status");

        // Reset in the middle of RUN
        wr(ADDR_LEN, 32'd4);
        start_run(32'h1, t0);
        @(posedge clk);
        #1;
        chk("mid_busy", 32'(leds[6]), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_leds", 32'(leds), 32'd0);
        chk("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rd_chk(ADDR_RESULT, 32'd0, "mid_rst_result");
        rd_chk(ADDR_STATUS, 32'd0, "mid_rst_status");

        // LEN clamping
        wr(ADDR_LEN, 32'd0);
        rd_chk(ADDR_LEN, 32'd1, "len_zero");
        wr(ADDR_LEN, 32'd100);
        rd_chk(ADDR_LEN, 32'd64, "len_over");
        wr(ADDR_LEN, 32'd37);
        rd_chk(ADDR_LEN, 32'd37, "len_mid");

        // Read and write in the same cycle: read sees the old value
        @(negedge clk);
        bus.avs_address   = ADDR_LEN;
        bus.avs_writedata = 32'd5;
        bus.avs_write     = 1'b1;
        bus.avs_read      = 1'b1;
        @(posedge clk);
        #1;
        bus.avs_write     = 1'b0;
        bus.avs_read      = 1'b0;
        chk("rw_same_cycle", bus.avs_readdata, 32'd37);
        rd_chk(ADDR_LEN, 32'd5, "rw_after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ann_mac_slave.md
Name: ann_mac_slave

Overview:
- Avalon-MM slave in the FPGA fabric, behind the HPS lightweight HPS-to-FPGA bridge. It is the responder end of the bus that the HPS master drives, and it sits alongside the LED PIO.
- The HPS software loads an input vector and a weight vector, starts the block, and reads back one neuron's dot product.
- The result is optionally passed through ReLU and saturated.
- A single block computes one neuron. Software iterates over neurons.

Parameters:
- DATA_W, 16, signed element width for inputs and weights.
- DEPTH, 64, maximum vector length; power of 2.
- ACC_W, 40, internal accumulator width; must be at least 2*DATA_W + log2(DEPTH).

Ports:
- clk_clk  in  1  single clock, shared with the bridge.
- reset_reset  in  1  synchronous reset, active-high.
- avs_address  in  3  word address.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_read  in  1  read strobe.
- avs_readdata  out  32  read data; fixed read latency of 1.
- avs_waitrequest  out  1  tied to 0; the slave never stalls.
- irq  out  1  level interrupt; high while DONE=1 and IRQ_EN=1.
- status_leds  out  8  {done, busy, err, ovf, 4'b0}, for the LED header.

Behaviour:
- Register map (word address):
  - 0 CTRL. Write: b0 START, b1 CLR_PTR, b2 RELU_EN, b3 IRQ_EN. Read: {28'b0, IRQ_EN, RELU_EN, ...}. STATUS carries busy and done.
  - 1 LEN. R/W, 7 bits, value in 1..DEPTH. Write 0 -> stored as 1. Write above DEPTH -> stored as DEPTH.
  - 2 XDATA. Write-only. Writes the low DATA_W bits to x_mem[xptr], then xptr increments. xptr wraps to 0 at DEPTH.
  - 3 WDATA. Same as XDATA, for w_mem and wptr.
  - 4 RESULT. Read-only; last result as a 32-bit signed value.
  - 5 STATUS. Read: b0 busy, b1 done, b2 err, b3 ovf, b15:8 xptr, b23:16 wptr. Writing 1 to b1, b2 or b3 clears that bit.
  - 6, 7. Read as 0; writes are ignored.
- Reset values:
  - readdata = 0, irq = 0, status_leds = 0.
  - LEN = 1, pointers = 0, RELU_EN = 0, IRQ_EN = 0.
  - busy, done, err, ovf = 0. RESULT = 0. FSM = IDLE.
  - Memory contents are not reset.
- Reads: avs_readdata is registered and valid the cycle after avs_read. If avs_read and avs_write occur in the same cycle, the write takes effect and the read returns the pre-write value.
- CLR_PTR: sets xptr and wptr to 0 on the next cycle. If START and CLR_PTR are written together, CLR_PTR is applied and START is ignored.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on a START write. The cycle after the write: acc = 0, idx = 0, busy = 1, done = 0.
  - RUN: issue a read of x_mem[idx] and w_mem[idx] each cycle, idx++. Go to DRAIN after issuing idx = LEN-1.
  - DRAIN: wait 2 cycles for the pipeline to empty.
  - DONE: result written, busy = 0, done = 1. Return to IDLE in the same cycle.
- Pipeline: memory read (1 cycle) -> registered signed product 2*DATA_W (1 cycle) -> accumulate into ACC_W, sign-extended.
- Latency: busy falls and done rises exactly LEN+3 cycles after the START write cycle.
- Result stage:
  - If RELU_EN=1 and acc < 0, the value is 0.
  - Otherwise the value is saturated to int32 (0x7FFFFFFF or 0x80000000), and ovf is set when saturation occurs.
- While busy:
  - Writes to XDATA, WDATA, LEN, or a START write are ignored and set err. Pointers do not move.
  - CTRL writes of RELU_EN and IRQ_EN still take effect.
  - A STATUS clear of done is ignored.
- Reset mid-RUN: returns to IDLE on the next edge. RESULT = 0, done = 0.
- A done clear and a DONE transition in the same cycle: the DONE transition wins, so done = 1.

Decomposition:
- Package ann_mac_pkg:
  - Register address localparams (ADDR_CTRL ... ADDR_STATUS).
  - CTRL and STATUS bit indices.
  - FSM state enum.
  - sat32 function.
- Sub-module ann_mac_unit:
  - Holds the product register and the accumulator.
  - Inputs: clear, valid, x, w. Output: acc.
- The top level holds the CSR, the two inferred RAMs and the FSM.

Test Plan:
- Basic dot product. Reset, LEN=4, X={1,2,3,4}, W={5,6,7,8}, START -> busy for 7 cycles, RESULT=70, done=1, ovf=0, irq=0.
- Signed inputs with ReLU. X={-3,2}, W={4,1}, LEN=2. With RELU_EN=0 -> RESULT=0xFFFFFFF6. With RELU_EN=1 -> RESULT=0.
- Saturation. LEN=64, all X=W=0x7FFF -> RESULT=0x7FFFFFFF, ovf=1. Write STATUS b3=1 -> ovf=0.
- Busy protection. Write XDATA=9 during RUN -> err=1, xptr unchanged, RESULT unaffected. START during RUN -> ignored.
- Interrupt and pointers. Set IRQ_EN, run LEN=1 -> irq=1 after 4 cycles. Clearing done -> irq=0. Write 65 words to XDATA -> xptr=1 (wrap). CLR_PTR -> xptr=0.
- Reset mid-RUN. Assert reset_reset 2 cycles after START -> next cycle busy=0, done=0, readdata of RESULT=0. LEN write of 0 -> reads 1.
